cnn_pool_stream: RTL and testbench

//  Parametrised streaming 2x2/stride-2 pooling stage for the CNN pipeline; successor to the fixed pool layer.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/pool_line_buf.sv | 33 +++
 rtl/cnn_pool_stream.sv | 179 +++++++++++++++++
 tb/tb_cnn_pool_stream.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pooling stage: mode encoding, FSM states and
// the signed compare helper.
package cnn_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Working width of sat_max; callers sign-extend into it and truncate the result.
  localparam int SMW = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_t;

  function automatic logic signed [SMW-1:0] sat_max(
    input logic signed [SMW-1:0] a,
    input logic signed [SMW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-write/one-read synchronous RAM holding the even-row horizontal pair
// results; registered read data holds between read enables.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int WIDTH = 34,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cnn_pool_stream.sv
// Streaming 2x2/stride-2 max/average pooling over CH parallel channels with
// video-style output framing and sticky frame-error detection.
module cnn_pool_stream
  import cnn_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CH   = 2,
  parameter int IN_W = 24,
  parameter int IN_H = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pool_mode,
  input  logic [CH*DW-1:0] act_data,
  input  logic             act_data_vld,
  output logic [CH*DW-1:0] pool_data,
  output logic             pool_data_vld,
  output logic             active_video,
  output logic             vid_hsync,
  output logic             vid_vsync,
  output logic             vid_ce,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LB_D  = IN_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam int PW    = DW + 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_w
    $error("cnn_pool_stream: IN_W must be even and at least 2");
  end
  if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_h
    $error("cnn_pool_stream: IN_H must be even and at least 2");
  end

  pool_state_t       r_state, w_state_nxt;
  logic [CW-1:0]     r_col, w_col;
  logic [RW-1:0]     r_row, w_row;
  logic              r_mode;
  logic [CH*DW-1:0]  r_h;
  logic              w_accept, w_err_set, w_col_odd, w_row_odd;
  logic              w_last_col, w_last_pix, w_emit, w_lb_we, w_lb_re;
  logic [LB_AW-1:0]  w_lb_addr;
  logic [CH*PW-1:0]  w_pair_all, w_lb_rdata;
  logic [CH*DW-1:0]  w_pool_nxt;

  logic [CH*DW-1:0]  r_pool_data;
  logic              r_pool_vld, r_active, r_hsync, r_vsync, r_done, r_err;

  // A frame_start beat is pixel (0,0) of the new frame, so position is forced to zero.
  assign w_col      = frame_start ? '0 : r_col;
  assign w_row      = frame_start ? '0 : r_row;
  assign w_accept   = act_data_vld && (frame_start || r_state == ST_RUN);
  assign w_err_set  = (act_data_vld && !w_accept) || (frame_start && r_state == ST_RUN);
  assign w_col_odd  = w_col[0];
  assign w_row_odd  = w_row[0];
  assign w_last_col = (w_col == COL_LAST);
  assign w_last_pix = w_last_col && (w_row == ROW_LAST);
  assign w_emit     = w_accept && w_col_odd && w_row_odd;
  assign w_lb_addr  = LB_AW'(w_col >> 1);
  assign w_lb_we    = w_accept && w_col_odd && !w_row_odd;
  assign w_lb_re    = w_accept && !w_col_odd && w_row_odd;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (frame_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_accept && w_last_pix) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = frame_start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_mode  <= POOL_MAX;
      r_h     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (frame_start) begin
        r_mode <= pool_mode;
      end
      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
        if (!w_col_odd) begin
          r_h <= act_data;
        end
      end else if (frame_start) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  pool_line_buf #(
    .DEPTH (LB_D),
    .WIDTH (CH * PW),
    .AW    (LB_AW)
  ) u_line_buf (
    .i_clk     (clk),
    .i_wr_en   (w_lb_we),
    .i_wr_addr (w_lb_addr),
    .i_wr_data (w_pair_all),
    .i_rd_en   (w_lb_re),
    .i_rd_addr (w_lb_addr),
    .o_rd_data (w_lb_rdata)
  );

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0] w_a, w_b;
    logic signed [PW-1:0] w_pair, w_up;
    logic signed [PW:0]   w_sum;

    assign w_a    = r_h[c*DW +: DW];
    assign w_b    = act_data[c*DW +: DW];
    assign w_pair = (r_mode == POOL_AVG) ? (PW'(w_a) + PW'(w_b))
                                         : PW'(sat_max(SMW'(w_a), SMW'(w_b)));
    assign w_up   = w_lb_rdata[c*PW +: PW];
    // Four-sample sum needs DW+2 bits; the arithmetic shift floors toward -inf.
    assign w_sum  = (PW + 1)'(w_up) + (PW + 1)'(w_pair);

    assign w_pair_all[c*PW +: PW] = w_pair;
    assign w_pool_nxt[c*DW +: DW] = (r_mode == POOL_AVG) ? DW'(w_sum >>> 2)
                                    : DW'(sat_max(SMW'(w_up), SMW'(w_pair)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pool_data <= '0;
      r_pool_vld  <= 1'b0;
      r_active    <= 1'b0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pool_vld <= w_emit;
      if (w_emit) begin
        r_pool_data <= w_pool_nxt;
      end
      r_hsync <= w_emit && w_last_col;
      r_vsync <= w_emit && (w_col == CW'(1)) && (w_row == RW'(1));
      if (frame_start) begin
        r_active <= 1'b0;
      end else if (w_emit) begin
        r_active <= 1'b1;
      end else if (r_hsync) begin
        r_active <= 1'b0;
      end
      r_done <= (r_state == ST_DONE);
      r_err  <= (frame_start ? 1'b0 : r_err) | w_err_set;
    end
  end

  assign pool_data     = r_pool_data;
  assign pool_data_vld = r_pool_vld;
  assign vid_ce        = r_pool_vld;
  assign active_video  = r_active;
  assign vid_hsync     = r_hsync;
  assign vid_vsync     = r_vsync;
  assign frame_done    = r_done;
  assign frame_err     = r_err;

endmodule

// File: tb/tb_cnn_pool_stream.sv
// Directed bench for cnn_pool_stream: 4x4 and 2x2 instances for hand-computed
// vectors, a default 24x24 instance for gapped frames against a window-max model.
module tb_cnn_pool_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic        fs4, md4, v4;
  logic [31:0] d4, pd4;
  logic        pv4, av4, hs4, vs4, ce4, fd4, er4;

  logic        fs2, md2, v2;
  logic [31:0] d2, pd2;
  logic        pv2, av2, hs2, vs2, ce2, fd2, er2;

  logic        fs24, md24, v24;
  logic [31:0] d24, pd24;
  logic        pv24, av24, hs24, vs24, ce24, fd24, er24;

  cnn_pool_stream #(.DW(16), .CH(2), .IN_W(4), .IN_H(4)) u_dut4 (
    .clk(clk), .rst(rst), .frame_start(fs4), .pool_mode(md4),
    .act_data(d4), .act_data_vld(v4), .pool_data(pd4), .pool_data_vld(pv4),
    .active_video(av4), .vid_hsync(hs4), .vid_vsync(vs4), .vid_ce(ce4),
    .frame_done(fd4), .frame_err(er4)
  );

  cnn_pool_stream #(.DW(16), .CH(2), .IN_W(2), .IN_H(2)) u_dut2 (
    .clk(clk), .rst(rst), .frame_start(fs2), .pool_mode(md2),
    .act_data(d2), .act_data_vld(v2), .pool_data(pd2), .pool_data_vld(pv2),
    .active_video(av2), .vid_hsync(hs2), .vid_vsync(vs2), .vid_ce(ce2),
    .frame_done(fd2), .frame_err(er2)
  );

  cnn_pool_stream u_dut24 (
    .clk(clk), .rst(rst), .frame_start(fs24), .pool_mode(md24),
    .act_data(d24), .act_data_vld(v24), .pool_data(pd24), .pool_data_vld(pv24),
    .active_video(av24), .vid_hsync(hs24), .vid_vsync(vs24), .vid_ce(ce24),
    .frame_done(fd24), .frame_err(er24)
  );

  // Output capture for the 24x24 instance, plus an active_video expectation
  // built from the spec: high on each output pixel and between the pixels of a row.
  logic [33:0] q24[$];
  int n_hs = 0, n_vs = 0, n_act_bad = 0;
  bit in_row = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_row = 1'b0;
    end else begin
      if (av24 !== (pv24 || in_row)) n_act_bad++;
      if (pv24) begin
        q24.push_back({pd24, hs24, vs24});
        if (hs24) n_hs++;
        if (vs24) n_vs++;
        in_row = !hs24;
      end
      if (fs24) in_row = 1'b0;
    end
  end

  int   img0[576], img1[576];
  logic err_at_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic send_frame24(input int nbeats, input logic mode);
    logic [15:0] s0, s1;
    int i;
    fs24 = 1'b1; md24 = mode; v24 = 1'b0;
    tick();
    fs24 = 1'b0;
    err_at_start = er24;
    i = 0;
    while (i < nbeats) begin
      if ($urandom_range(1, 0) == 1) begin
        s0 = 16'($urandom);
        s1 = 16'($urandom);
        img0[i] = int'($signed(s0));
        img1[i] = int'($signed(s1));
        d24 = {s1, s0};
        v24 = 1'b1;
        i++;
      end else begin
        v24 = 1'b0;
      end
      tick();
    end
    v24 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic check_frame24(input string tag, input int base);
    int m0, m1, o, ix;
    logic [33:0] e;
    check({tag, "_cnt"}, q24.size() - base, 144);
    for (int oy = 0; oy < 12; oy++) begin
      for (int ox = 0; ox < 12; ox++) begin
        o  = oy * 12 + ox;
        m0 = -100000;
        m1 = -100000;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            ix = (2 * oy + dy) * 24 + 2 * ox + dx;
            if (img0[ix] > m0) m0 = img0[ix];
            if (img1[ix] > m1) m1 = img1[ix];
          end
        end
        e = {16'(m1), 16'(m0), ox == 11, o == 0};
        if (base + o < q24.size()) check({tag, "_px"}, q24[base + o], e);
      end
    end
  endtask

  int e0[4] = '{5, 7, 13, 15};
  int e1[4] = '{0, -2, -8, -10};
  int a0[4] = '{-1, -2, -3, -4};
  int a1[4] = '{1, 2, 3, 5};
  int o0[4], o1[4];
  int k, p, base, hs_base, vs_base;
  bit exp_vld, exp_act, prev_hs;

  initial begin
    rst = 1'b1;
    fs4 = 1'b0;  md4 = 1'b0;  v4 = 1'b0;  d4 = '0;
    fs2 = 1'b0;  md2 = 1'b0;  v2 = 1'b0;  d2 = '0;
    fs24 = 1'b0; md24 = 1'b0; v24 = 1'b0; d24 = '0;
    repeat (3) tick();
    check("rst_u24", {pd24, pv24, av24, hs24, vs24, ce24, fd24, er24}, 0);
    check("rst_u4",  {pd4, pv4, av4, hs4, vs4, ce4, fd4, er4}, 0);
    rst = 1'b0;
    tick();

    // 4x4 max ramp, continuous valid
    md4 = 1'b0; fs4 = 1'b1;
    tick();
    fs4 = 1'b0;
    k = 0; exp_act = 1'b0; prev_hs = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p = r * 4 + c;
        d4 = {16'(-p), 16'(p)}; v4 = 1'b1;
        tick();
        exp_vld = (r % 2 == 1) && (c % 2 == 1);
        exp_act = exp_vld ? 1'b1 : (prev_hs ? 1'b0 : exp_act);
        check("t1_vld", pv4, exp_vld);
        check("t1_ce", ce4, exp_vld);
        check("t1_act", av4, exp_act);
        check("t1_done", fd4, 0);
        prev_hs = 1'b0;
        if (exp_vld) begin
          check("t1_ch0", $signed(pd4[15:0]), e0[k]);
          check("t1_ch1", $signed(pd4[31:16]), e1[k]);
          check("t1_hs", hs4, k % 2 == 1);
          check("t1_vs", vs4, k == 0);
          prev_hs = (k % 2 == 1);
          k++;
        end
      end
    end
    v4 = 1'b0;
    tick();
    check("t1_done_pulse", fd4, 1);
    check("t1_vld_after", pv4, 0);
    check("t1_act_after", av4, 0);
    tick();
    check("t1_done_end", fd4, 0);
    check("t1_err", er4, 0);
    repeat (2) tick();

    // frame_start with the first beat; mode input toggled mid-frame
    md4 = 1'b0; fs4 = 1'b1; k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p = r * 4 + c;
        d4 = {16'(-p), 16'(p)}; v4 = 1'b1;
        if (p == 6) md4 = 1'b1;
        tick();
        fs4 = 1'b0;
        if (pv4) begin
          if (k < 4) begin
            o0[k] = int'($signed(pd4[15:0]));
            o1[k] = int'($signed(pd4[31:16]));
          end
          k++;
        end
      end
    end
    v4 = 1'b0; md4 = 1'b0;
    tick();
    check("t6_cnt", k, 4);
    for (int i = 0; i < 4; i++) begin
      check("t6_ch0", o0[i], e0[i]);
      check("t6_ch1", o1[i], e1[i]);
    end
    check("t6_err", er4, 0);

    // 2x2 average: ch0 -1,-2,-3,-4 -> -3 ; ch1 1,2,3,5 -> 2
    md2 = 1'b1; fs2 = 1'b1;
    tick();
    fs2 = 1'b0; md2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d2 = {16'(a1[i]), 16'(a0[i])}; v2 = 1'b1;
      tick();
      if (i < 3) check("t2_vld_early", pv2, 0);
    end
    v2 = 1'b0;
    check("t2_vld", pv2, 1);
    check("t2_ch0", $signed(pd2[15:0]), -3);
    check("t2_ch1", $signed(pd2[31:16]), 2);
    check("t2_sync", {hs2, vs2, av2}, 3'b111);
    tick();
    check("t2_done", {pv2, fd2, av2}, 3'b010);

    // 24x24 max with ~50% valid gaps
    base = q24.size(); hs_base = n_hs; vs_base = n_vs;
    send_frame24(576, 1'b0);
    check("t3_err_start", err_at_start, 0);
    check_frame24("t3", base);
    check("t3_hsync", n_hs - hs_base, 12);
    check("t3_vsync", n_vs - vs_base, 1);
    check("t3_active", n_act_bad, 0);
    check("t3_err", er24, 0);

    // restart after 30 beats
    send_frame24(30, 1'b0);
    check("t4_err_before", er24, 0);
    base = q24.size();
    send_frame24(576, 1'b0);
    check("t4_err_set", err_at_start, 1);
    check("t4_err_sticky", er24, 1);
    check_frame24("t4", base);

    // reset in the middle of row 7
    base = q24.size();
    send_frame24(7 * 24 + 10, 1'b0);
    check("t5_err_clr", err_at_start, 0);
    check("t5_out_pre", q24.size() - base, 41);
    check("t5_act_pre", av24, 1);
    rst = 1'b1;
    tick();
    check("t5_rst_out", {pd24, pv24, av24, hs24, vs24, ce24, fd24, er24}, 0);
    rst = 1'b0;
    tick();
    base = q24.size();
    d24 = 32'h0001_0001; v24 = 1'b1;
    repeat (10) tick();
    v24 = 1'b0;
    repeat (3) tick();
    check("t5_ignored", q24.size() - base, 0);
    check("t5_err_idle", er24, 1);
    base = q24.size();
    send_frame24(576, 1'b0);
    check("t5_err_clr2", err_at_start, 0);
    check_frame24("t5", base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
